// File: rtl/rs_alu_pkg.sv
// Shared constants for the ALU reservation station: sizing defaults, opcode/funct3 encodings, operand-use helpers.
package rs_alu_pkg;

    localparam int RS_DEPTH = 8;
    localparam int RS_ROB_W = 4;

    typedef enum logic [6:0] {
        OPCODE_LUI   = 7'b0110111,
        OPCODE_AUIPC = 7'b0010111,
        OPCODE_JAL   = 7'b1101111,
        OPCODE_JALR  = 7'b1100111,
        OPCODE_BR    = 7'b1100011,
        OPCODE_CALCI = 7'b0010011,
        OPCODE_CALC  = 7'b0110011
    } opcode_e;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SRL  = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    function automatic logic op_has_rs1(input logic [6:0] op);
        return !(op == OPCODE_LUI || op == OPCODE_AUIPC || op == OPCODE_JAL);
    endfunction

    function automatic logic op_has_rs2(input logic [6:0] op);
        return (op == OPCODE_BR || op == OPCODE_CALC);
    endfunction

endpackage

// File: rtl/rs_select.sv
// Picks one ready entry: lowest index by default, oldest-ready when RS_AGE_SELECT_EN is defined.
// Purely combinational; age[i][j]=1 means entry j was inserted before entry i and is still live.
module rs_select
    import rs_alu_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            ready,
`ifdef RS_AGE_SELECT_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
`endif
    output logic [DEPTH-1:0]            grant,
    output logic                        found,
    output logic [IDX_W-1:0]            grant_idx
);

    always_comb begin
        grant     = '0;
        found     = 1'b0;
        grant_idx = '0;
        // Descending scan so the last hit, i.e. the lowest qualifying index, wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
`ifdef RS_AGE_SELECT_EN
            if (ready[i] && ((age[i] & ready) == '0)) begin
`else
            if (ready[i]) begin
`endif
                found     = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        grant[grant_idx] = found;
    end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds ops until operands arrive via CDB snoop, issues one ready op per cycle (1 cycle entry->alu_en).
// rs_full stalls dispatch; rdy=0 freezes everything; RS_AGE_SELECT_EN selects oldest-ready instead of lowest-index.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int ROB_W = RS_ROB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             issue_valid,
    input  logic [6:0]       issue_opcode,
    input  logic [2:0]       issue_funct3,
    input  logic             issue_funct7,
    input  logic             issue_rs1_pend,
    input  logic [ROB_W-1:0] issue_rs1_tag,
    input  logic [31:0]      issue_rs1_val,
    input  logic             issue_rs2_pend,
    input  logic [ROB_W-1:0] issue_rs2_tag,
    input  logic [31:0]      issue_rs2_val,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic [ROB_W-1:0] issue_rob_pos,
    output logic             rs_full,
    input  logic             alu_cdb_valid,
    input  logic [ROB_W-1:0] alu_cdb_rob_pos,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [ROB_W-1:0] lsb_cdb_rob_pos,
    input  logic [31:0]      lsb_cdb_val,
    output logic             alu_en,
    output logic [6:0]       alu_opcode,
    output logic [2:0]       alu_funct3,
    output logic             alu_funct7,
    output logic [31:0]      alu_val1,
    output logic [31:0]      alu_val2,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [ROB_W-1:0] alu_rob_pos
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] vld_q, vld_d, p1_q, p1_d, p2_q, p2_d, f7_q, f7_d;
    logic [6:0]       op_q  [DEPTH];
    logic [6:0]       op_d  [DEPTH];
    logic [2:0]       f3_q  [DEPTH];
    logic [2:0]       f3_d  [DEPTH];
    logic [ROB_W-1:0] t1_q  [DEPTH];
    logic [ROB_W-1:0] t1_d  [DEPTH];
    logic [ROB_W-1:0] t2_q  [DEPTH];
    logic [ROB_W-1:0] t2_d  [DEPTH];
    logic [ROB_W-1:0] rob_q [DEPTH];
    logic [ROB_W-1:0] rob_d [DEPTH];
    logic [31:0]      v1_q  [DEPTH];
    logic [31:0]      v1_d  [DEPTH];
    logic [31:0]      v2_q  [DEPTH];
    logic [31:0]      v2_d  [DEPTH];
    logic [31:0]      imm_q [DEPTH];
    logic [31:0]      imm_d [DEPTH];
    logic [31:0]      pc_q  [DEPTH];
    logic [31:0]      pc_d  [DEPTH];

    logic             alu_en_q, alu_en_d, alu_funct7_q, alu_funct7_d;
    logic [6:0]       alu_opcode_q, alu_opcode_d;
    logic [2:0]       alu_funct3_q, alu_funct3_d;
    logic [31:0]      alu_val1_q, alu_val1_d, alu_val2_q, alu_val2_d;
    logic [31:0]      alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
    logic [ROB_W-1:0] alu_rob_pos_q, alu_rob_pos_d;

`ifdef RS_AGE_SELECT_EN
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
`endif

    logic [DEPTH-1:0] ready, grant;
    logic             found, ins_vld;
    logic [IDX_W-1:0] sel_idx, ins_idx;
    logic             in_p1, in_p2;
    logic [31:0]      in_v1, in_v2;

    assign rs_full = &vld_q;
    assign ready   = vld_q & ~p1_q & ~p2_q;
    assign ins_vld = issue_valid && !rs_full;

    rs_select #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_select (
        .ready     (ready),
`ifdef RS_AGE_SELECT_EN
        .age       (age_q),
`endif
        .grant     (grant),
        .found     (found),
        .grant_idx (sel_idx)
    );

    // Free slot comes from start-of-cycle state, so a slot vacated by this cycle's issue is not reused yet.
    always_comb begin
        ins_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) ins_idx = IDX_W'(i);
        end
    end

    always_comb begin
        in_p1 = issue_rs1_pend;
        in_v1 = issue_rs1_val;
        in_p2 = issue_rs2_pend;
        in_v2 = issue_rs2_val;
        if (issue_rs1_pend && alu_cdb_valid && issue_rs1_tag == alu_cdb_rob_pos) begin
            in_p1 = 1'b0;
            in_v1 = alu_cdb_val;
        end else if (issue_rs1_pend && lsb_cdb_valid && issue_rs1_tag == lsb_cdb_rob_pos) begin
            in_p1 = 1'b0;
            in_v1 = lsb_cdb_val;
        end
        if (issue_rs2_pend && alu_cdb_valid && issue_rs2_tag == alu_cdb_rob_pos) begin
            in_p2 = 1'b0;
            in_v2 = alu_cdb_val;
        end else if (issue_rs2_pend && lsb_cdb_valid && issue_rs2_tag == lsb_cdb_rob_pos) begin
            in_p2 = 1'b0;
            in_v2 = lsb_cdb_val;
        end
    end

    always_comb begin
        vld_d = vld_q;  p1_d = p1_q;  p2_d = p2_q;  f7_d = f7_q;
        op_d  = op_q;   f3_d = f3_q;  t1_d = t1_q;  t2_d = t2_q;  rob_d = rob_q;
        v1_d  = v1_q;   v2_d = v2_q;  imm_d = imm_q; pc_d = pc_q;
        alu_en_d      = 1'b0;
        alu_opcode_d  = alu_opcode_q;
        alu_funct3_d  = alu_funct3_q;
        alu_funct7_d  = alu_funct7_q;
        alu_val1_d    = alu_val1_q;
        alu_val2_d    = alu_val2_q;
        alu_imm_d     = alu_imm_q;
        alu_pc_d      = alu_pc_q;
        alu_rob_pos_d = alu_rob_pos_q;
`ifdef RS_AGE_SELECT_EN
        age_d = age_q;
`endif

        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && p1_q[i]) begin
                if (alu_cdb_valid && t1_q[i] == alu_cdb_rob_pos) begin
                    p1_d[i] = 1'b0;
                    v1_d[i] = alu_cdb_val;
                end else if (lsb_cdb_valid && t1_q[i] == lsb_cdb_rob_pos) begin
                    p1_d[i] = 1'b0;
                    v1_d[i] = lsb_cdb_val;
                end
            end
            if (vld_q[i] && p2_q[i]) begin
                if (alu_cdb_valid && t2_q[i] == alu_cdb_rob_pos) begin
                    p2_d[i] = 1'b0;
                    v2_d[i] = alu_cdb_val;
                end else if (lsb_cdb_valid && t2_q[i] == lsb_cdb_rob_pos) begin
                    p2_d[i] = 1'b0;
                    v2_d[i] = lsb_cdb_val;
                end
            end
        end

        if (found) begin
            vld_d[sel_idx] = 1'b0;
            alu_en_d       = 1'b1;
            alu_opcode_d   = op_q[sel_idx];
            alu_funct3_d   = f3_q[sel_idx];
            alu_funct7_d   = f7_q[sel_idx];
            alu_val1_d     = v1_q[sel_idx];
            alu_val2_d     = v2_q[sel_idx];
            alu_imm_d      = imm_q[sel_idx];
            alu_pc_d       = pc_q[sel_idx];
            alu_rob_pos_d  = rob_q[sel_idx];
        end

        if (ins_vld) begin
            vld_d[ins_idx] = 1'b1;
            op_d[ins_idx]  = issue_opcode;
            f3_d[ins_idx]  = issue_funct3;
            f7_d[ins_idx]  = issue_funct7;
            p1_d[ins_idx]  = in_p1;
            t1_d[ins_idx]  = issue_rs1_tag;
            v1_d[ins_idx]  = in_v1;
            p2_d[ins_idx]  = in_p2;
            t2_d[ins_idx]  = issue_rs2_tag;
            v2_d[ins_idx]  = in_v2;
            imm_d[ins_idx] = issue_imm;
            pc_d[ins_idx]  = issue_pc;
            rob_d[ins_idx] = issue_rob_pos;
        end

`ifdef RS_AGE_SELECT_EN
        // The freed entry drops out of every row; a new entry is younger than everything surviving.
        for (int j = 0; j < DEPTH; j++) begin
            if (grant[j]) begin
                for (int i = 0; i < DEPTH; i++) age_d[i][j] = 1'b0;
            end
        end
        if (ins_vld) age_d[ins_idx] = vld_q & ~grant;
`endif

        if (rollback) begin
            vld_d         = '0;
            p1_d          = '0;
            p2_d          = '0;
            alu_en_d      = 1'b0;
            alu_opcode_d  = '0;
            alu_funct3_d  = '0;
            alu_funct7_d  = 1'b0;
            alu_val1_d    = '0;
            alu_val2_d    = '0;
            alu_imm_d     = '0;
            alu_pc_d      = '0;
            alu_rob_pos_d = '0;
`ifdef RS_AGE_SELECT_EN
            age_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q         <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            alu_en_q      <= 1'b0;
            alu_opcode_q  <= '0;
            alu_funct3_q  <= '0;
            alu_funct7_q  <= 1'b0;
            alu_val1_q    <= '0;
            alu_val2_q    <= '0;
            alu_imm_q     <= '0;
            alu_pc_q      <= '0;
            alu_rob_pos_q <= '0;
`ifdef RS_AGE_SELECT_EN
            age_q         <= '0;
`endif
        end else if (rdy) begin
            vld_q         <= vld_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            alu_en_q      <= alu_en_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_funct3_q  <= alu_funct3_d;
            alu_funct7_q  <= alu_funct7_d;
            alu_val1_q    <= alu_val1_d;
            alu_val2_q    <= alu_val2_d;
            alu_imm_q     <= alu_imm_d;
            alu_pc_q      <= alu_pc_d;
            alu_rob_pos_q <= alu_rob_pos_d;
`ifdef RS_AGE_SELECT_EN
            age_q         <= age_d;
`endif
        end
    end

    // Payload is only consumed behind vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            op_q  <= op_d;
            f3_q  <= f3_d;
            f7_q  <= f7_d;
            t1_q  <= t1_d;
            t2_q  <= t2_d;
            rob_q <= rob_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            imm_q <= imm_d;
            pc_q  <= pc_d;
        end
    end

    assign alu_en      = alu_en_q;
    assign alu_opcode  = alu_opcode_q;
    assign alu_funct3  = alu_funct3_q;
    assign alu_funct7  = alu_funct7_q;
    assign alu_val1    = alu_val1_q;
    assign alu_val2    = alu_val2_q;
    assign alu_imm     = alu_imm_q;
    assign alu_pc      = alu_pc_q;
    assign alu_rob_pos = alu_rob_pos_q;

    a_no_dup_cdb_tag: assert property (@(posedge clk) disable iff (rst)
        !(alu_cdb_valid && lsb_cdb_valid && alu_cdb_rob_pos == lsb_cdb_rob_pos));
    a_rs1_unused_not_pend: assert property (@(posedge clk) disable iff (rst)
        (issue_valid && !op_has_rs1(issue_opcode)) |-> !issue_rs1_pend);
    a_rs2_unused_not_pend: assert property (@(posedge clk) disable iff (rst)
        (issue_valid && !op_has_rs2(issue_opcode)) |-> !issue_rs2_pend);
    c_issue_while_full: cover property (@(posedge clk) disable iff (rst)
        issue_valid && rs_full && rdy);

endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios plus randomized traffic, all checked against a slot-level model.
module tb_rs_alu;
    import rs_alu_pkg::*;

    localparam int DEPTH = 8;
    localparam int ROB_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, rdy, rollback, issue_valid;
    logic [6:0]       issue_opcode;
    logic [2:0]       issue_funct3;
    logic             issue_funct7;
    logic             issue_rs1_pend, issue_rs2_pend;
    logic [ROB_W-1:0] issue_rs1_tag, issue_rs2_tag, issue_rob_pos;
    logic [31:0]      issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
    logic             rs_full;
    logic             alu_cdb_valid, lsb_cdb_valid;
    logic [ROB_W-1:0] alu_cdb_rob_pos, lsb_cdb_rob_pos;
    logic [31:0]      alu_cdb_val, lsb_cdb_val;
    logic             alu_en, alu_funct7;
    logic [6:0]       alu_opcode;
    logic [2:0]       alu_funct3;
    logic [31:0]      alu_val1, alu_val2, alu_imm, alu_pc;
    logic [ROB_W-1:0] alu_rob_pos;

    rs_alu #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
        .issue_funct7(issue_funct7), .issue_rs1_pend(issue_rs1_pend), .issue_rs1_tag(issue_rs1_tag),
        .issue_rs1_val(issue_rs1_val), .issue_rs2_pend(issue_rs2_pend), .issue_rs2_tag(issue_rs2_tag),
        .issue_rs2_val(issue_rs2_val), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_rob_pos(issue_rob_pos), .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_pos(alu_cdb_rob_pos), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_pos(lsb_cdb_rob_pos), .lsb_cdb_val(lsb_cdb_val),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_rob_pos(alu_rob_pos)
    );

    typedef struct {
        bit v; bit [6:0] op; bit [2:0] f3; bit f7;
        bit p1; bit [3:0] t1; bit [31:0] v1;
        bit p2; bit [3:0] t2; bit [31:0] v2;
        bit [31:0] imm; bit [31:0] pc; bit [3:0] rob; int seq;
    } ent_t;

    typedef struct {
        bit en; bit [6:0] op; bit [2:0] f3; bit f7;
        bit [31:0] v1; bit [31:0] v2; bit [31:0] imm; bit [31:0] pc; bit [3:0] rob;
    } out_t;

    ent_t m [DEPTH];
    out_t eo;
    int   seq_ctr;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_full();
        for (int i = 0; i < DEPTH; i++) if (!m[i].v) return 1'b0;
        return 1'b1;
    endfunction

    // Resolve a source against the broadcasts: returns whether it is still waiting.
    function automatic bit still_pend(input bit p, input bit [3:0] t, inout bit [31:0] v);
        if (!p) return 1'b0;
        if (alu_cdb_valid && alu_cdb_rob_pos == t) begin v = alu_cdb_val; return 1'b0; end
        if (lsb_cdb_valid && lsb_cdb_rob_pos == t) begin v = lsb_cdb_val; return 1'b0; end
        return 1'b1;
    endfunction

    task automatic model_step();
        ent_t nm [DEPTH];
        int   sel, ins;
        if (rst || (rdy && rollback)) begin
            for (int i = 0; i < DEPTH; i++) m[i] = '{default: 0};
            eo = '{default: 0};
            return;
        end
        if (!rdy) return;
        sel = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v && !m[i].p1 && !m[i].p2) begin
                if (sel < 0) sel = i;
`ifdef RS_AGE_SELECT_EN
                else if (m[i].seq < m[sel].seq) sel = i;
`endif
            end
        end
        ins = -1;
        if (issue_valid && !model_full()) begin
            for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].v) ins = i;
        end
        nm = m;
        for (int i = 0; i < DEPTH; i++) begin
            if (nm[i].v) begin
                nm[i].p1 = still_pend(nm[i].p1, nm[i].t1, nm[i].v1);
                nm[i].p2 = still_pend(nm[i].p2, nm[i].t2, nm[i].v2);
            end
        end
        if (sel >= 0) begin
            eo = '{1'b1, m[sel].op, m[sel].f3, m[sel].f7, m[sel].v1, m[sel].v2,
                   m[sel].imm, m[sel].pc, m[sel].rob};
            nm[sel].v = 1'b0;
        end else begin
            eo.en = 1'b0;
        end
        if (ins >= 0) begin
            nm[ins].v   = 1'b1;
            nm[ins].op  = issue_opcode;   nm[ins].f3 = issue_funct3;  nm[ins].f7 = issue_funct7;
            nm[ins].t1  = issue_rs1_tag;  nm[ins].v1 = issue_rs1_val;
            nm[ins].t2  = issue_rs2_tag;  nm[ins].v2 = issue_rs2_val;
            nm[ins].p1  = still_pend(issue_rs1_pend, issue_rs1_tag, nm[ins].v1);
            nm[ins].p2  = still_pend(issue_rs2_pend, issue_rs2_tag, nm[ins].v2);
            nm[ins].imm = issue_imm;  nm[ins].pc = issue_pc;  nm[ins].rob = issue_rob_pos;
            nm[ins].seq = seq_ctr++;
        end
        m = nm;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("alu_en",   alu_en,      eo.en);
        chk("opcode",   alu_opcode,  eo.op);
        chk("funct3",   alu_funct3,  eo.f3);
        chk("funct7",   alu_funct7,  eo.f7);
        chk("val1",     alu_val1,    eo.v1);
        chk("val2",     alu_val2,    eo.v2);
        chk("imm",      alu_imm,     eo.imm);
        chk("pc",       alu_pc,      eo.pc);
        chk("rob_pos",  alu_rob_pos, eo.rob);
        chk("rs_full",  rs_full,     model_full());
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; issue_valid = 1'b0;
        alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
    endtask

    task automatic put(input bit [6:0] op, input bit p1, input bit [3:0] t1, input bit [31:0] v1,
                       input bit p2, input bit [3:0] t2, input bit [31:0] v2, input bit [3:0] rob);
        issue_valid = 1'b1; issue_opcode = op; issue_funct3 = FUNCT3_ADD; issue_funct7 = 1'b0;
        issue_rs1_pend = p1; issue_rs1_tag = t1; issue_rs1_val = v1;
        issue_rs2_pend = p2; issue_rs2_tag = t2; issue_rs2_val = v2;
        issue_imm = 32'h100 + 32'(rob); issue_pc = 32'h1000 + 32'(rob) * 4; issue_rob_pos = rob;
    endtask

    task automatic cdb(input bit on_alu, input bit [3:0] tag, input bit [31:0] val);
        if (on_alu) begin alu_cdb_valid = 1'b1; alu_cdb_rob_pos = tag; alu_cdb_val = val; end
        else        begin lsb_cdb_valid = 1'b1; lsb_cdb_rob_pos = tag; lsb_cdb_val = val; end
    endtask

    initial begin
        bit [6:0] ops [7];
        bit [6:0] op;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011};
        seq_ctr = 0;
        idle();
        put(7'b0110011, 0, 0, 0, 0, 0, 0, 0);
        issue_valid = 1'b0;
        alu_cdb_rob_pos = '0; alu_cdb_val = '0; lsb_cdb_rob_pos = '0; lsb_cdb_val = '0;
        rst = 1'b1;
        cycle();
        chk("reset_alu_en", alu_en, 0);
        chk("reset_full", rs_full, 0);

        // Ready ADD: stored at the first edge, granted and driven out at the next.
        idle(); put(OPCODE_CALC, 0, 0, 5, 0, 0, 7, 3); cycle();
        idle(); cycle();
        chk("t1_en", alu_en, 1); chk("t1_val1", alu_val1, 5);
        chk("t1_val2", alu_val2, 7); chk("t1_rob", alu_rob_pos, 3);
        idle(); cycle();
        chk("t1_freed", alu_en, 0);

        // ADDI waiting on tag 2, woken by the ALU broadcast.
        idle(); put(OPCODE_CALCI, 1, 2, 0, 0, 0, 0, 1); cycle();
        idle(); cycle(); cycle();
        idle(); cdb(1, 2, 32'h10); cycle();
        chk("t2_not_yet", alu_en, 0);
        idle(); cycle();
        chk("t2_en", alu_en, 1); chk("t2_val1", alu_val1, 32'h10);

        // Same-cycle bypass from the LSB broadcast.
        idle(); put(OPCODE_CALC, 0, 0, 1, 1, 5, 0, 6); cdb(0, 5, 32'hAB); cycle();
        idle(); cycle();
        chk("t3_en", alu_en, 1); chk("t3_val2", alu_val2, 32'hAB);

        // Fill all slots, ninth issue dropped, waking one frees a slot.
        for (int i = 0; i < DEPTH; i++) begin
            idle(); put(OPCODE_CALC, 1, 4'(8 + i), 0, 0, 0, 0, 4'(i)); cycle();
        end
        chk("t4_full", rs_full, 1);
        idle(); put(OPCODE_CALC, 0, 0, 9, 0, 0, 9, 15); cycle();
        chk("t4_still_full", rs_full, 1); chk("t4_drop", alu_en, 0);
        idle(); cdb(1, 8, 32'h77); cycle();
        chk("t4_full_woken", rs_full, 1);
        idle(); cycle();
        chk("t4_en", alu_en, 1); chk("t4_rob", alu_rob_pos, 0);
        chk("t4_not_full", rs_full, 0);

        // Rollback beats a simultaneous issue.
        idle(); rollback = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin
            idle(); put(OPCODE_CALC, 1, 1, 0, 0, 0, 0, 4'(i)); cycle();
        end
        idle(); rollback = 1'b1; put(OPCODE_CALC, 0, 0, 3, 0, 0, 4, 9); cycle();
        chk("t5_en", alu_en, 0); chk("t5_full", rs_full, 0); chk("t5_rob", alu_rob_pos, 0);
        idle(); cdb(1, 1, 32'h5); cycle();
        idle(); cycle();
        chk("t5_empty", alu_en, 0);

        // Freeze with alu_en high and a broadcast that must be ignored.
        idle(); put(OPCODE_CALC, 1, 6, 0, 0, 0, 2, 4); cycle();
        idle(); put(OPCODE_CALC, 0, 0, 32'h55, 0, 0, 3, 5); cycle();
        idle(); cycle();
        chk("t6_en", alu_en, 1); chk("t6_rob", alu_rob_pos, 5);
        for (int i = 0; i < 3; i++) begin
            idle(); rdy = 1'b0; cdb(1, 6, 32'h66); cycle();
            chk("t6_hold_en", alu_en, 1); chk("t6_hold_val1", alu_val1, 32'h55);
        end
        idle(); cycle();
        chk("t6_resume", alu_en, 0);
        idle(); cdb(1, 6, 32'h66); cycle();
        idle(); cycle();
        chk("t6_wake_en", alu_en, 1); chk("t6_wake_val1", alu_val1, 32'h66);
        chk("t6_wake_rob", alu_rob_pos, 4);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy      = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 49) == 0);
            op = ops[$urandom_range(0, 6)];
            issue_valid    = ($urandom_range(0, 2) != 0);
            issue_opcode   = op;
            issue_funct3   = 3'($urandom);
            issue_funct7   = 1'($urandom);
            issue_rs1_pend = op_allows_rs1(op) && ($urandom_range(0, 2) == 0);
            issue_rs2_pend = op_allows_rs2(op) && ($urandom_range(0, 2) == 0);
            issue_rs1_tag  = 4'($urandom_range(0, 7));
            issue_rs2_tag  = 4'($urandom_range(0, 7));
            issue_rs1_val  = $urandom;
            issue_rs2_val  = $urandom;
            issue_imm      = $urandom;
            issue_pc       = $urandom;
            issue_rob_pos  = 4'($urandom);
            alu_cdb_valid   = 1'($urandom);
            alu_cdb_rob_pos = 4'($urandom_range(0, 7));
            alu_cdb_val     = $urandom;
            lsb_cdb_valid   = 1'($urandom);
            lsb_cdb_rob_pos = 4'($urandom_range(0, 7));
            lsb_cdb_val     = $urandom;
            if (alu_cdb_valid && lsb_cdb_valid && alu_cdb_rob_pos == lsb_cdb_rob_pos)
                lsb_cdb_valid = 1'b0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic bit op_allows_rs1(input bit [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit op_allows_rs2(input bit [6:0] op);
        return (op == 7'b1100011 || op == 7'b0110011);
    endfunction

endmodule
